// File: rtl/mult4_seq_pkg.sv
// Shared definitions for the 4x4 sequential multiplier family:
// state encodings and the iteration count.
package mult4_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned MULT4_ITER = 4;
    localparam logic [2:0]  LAST_CNT   = 3'(MULT4_ITER - 1);

endpackage : mult4_seq_pkg

// File: rtl/mult4_seq_if.sv
// Request/result bundle of the sequential multiplier: operands and start
// in, busy/done status and product out.
interface mult4_seq_if;

    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] p;

    modport master (
        output start, a, b,
        input  busy, done, p
    );

    modport slave (
        input  start, a, b,
        output busy, done, p
    );

endinterface : mult4_seq_if

// File: rtl/mult4_seq_fulladder4.sv
// 4-bit ripple-carry adder; the only arithmetic element of the multiplier.
module fulladder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    // Ripple the carry through four full-adder bit slices
    always_comb begin
        logic carry_v;
        carry_v = ci;
        s       = 4'd0;
        for (int i = 0; i < 4; i++) begin
            s[i]    = a[i] ^ b[i] ^ carry_v;
            carry_v = (a[i] & b[i]) | (carry_v & (a[i] ^ b[i]));
        end
        co = carry_v;
    end

endmodule : fulladder4

// File: rtl/mult4_seq.sv
// Sequential 4x4 unsigned shift-and-add multiplier: one partial-product
// addition per cycle through fulladder4, 8-bit product after four iterations.
module mult4_seq
    import mult4_seq_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    mult4_seq_if.slave   bus
);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [3:0] mcand_r;
    logic [3:0] acc_r;
    logic [3:0] mq_r;
    logic [2:0] cnt_r;
    logic [7:0] p_r;
    logic       busy_r;
    logic       done_r;

    logic [3:0] sum_s;
    logic       co_s;
    logic [8:0] pre_shift_s;
    logic [7:0] step_s;
    logic       load_s;
    logic       iter_s;
    logic       last_s;

    fulladder4 u_add (
        .a  (acc_r),
        .b  (mcand_r),
        .ci (1'b0),
        .s  (sum_s),
        .co (co_s)
    );

    // Partial-product step; the adder carry lands in acc[3] after the shift
    always_comb begin
        pre_shift_s = 9'd0;
        if (mq_r[0]) begin
            pre_shift_s = {co_s, sum_s, mq_r};
        end else begin
            pre_shift_s = {1'b0, acc_r, mq_r};
        end
        step_s = pre_shift_s[8:1];
    end

    // Next-state and control decode
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        iter_s      = 1'b0;
        last_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    load_s      = 1'b1;
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                iter_s = 1'b1;
                if (cnt_r == LAST_CNT) begin
                    last_s      = 1'b1;
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                // A start here is accepted directly, giving one result per 5 cycles
                if (bus.start) begin
                    load_s      = 1'b1;
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered status/product
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            mcand_r <= 4'd0;
            acc_r   <= 4'd0;
            mq_r    <= 4'd0;
            cnt_r   <= 3'd0;
            p_r     <= 8'h00;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == ST_RUN);
            done_r  <= (state_nxt_s == ST_DONE);
            if (load_s) begin
                mcand_r <= bus.a;
                acc_r   <= 4'd0;
                mq_r    <= bus.b;
                cnt_r   <= 3'd0;
            end else if (iter_s) begin
                acc_r <= step_s[7:4];
                mq_r  <= step_s[3:0];
                cnt_r <= cnt_r + 3'd1;
                if (last_s) begin
                    p_r <= step_s;
                end
            end
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.p    = p_r;

endmodule : mult4_seq

// File: tb/tb_mult4_seq.sv
// Self-checking bench for mult4_seq: directed cases plus random operands
// compared against a plain a*b reference.
module tb_mult4_seq;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic [7:0] last_p;

    mult4_seq_if bus ();

    mult4_seq u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive operands with start; returns just after the accepting edge
    task automatic launch(input logic [3:0] ta, input logic [3:0] tb_v);
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_v;
        tick();
        bus.start = 1'b0;
    endtask

    // Entered just after the accepting edge: four RUN cycles, then done
    task automatic run_and_check(input string tag, input logic [3:0] ta, input logic [3:0] tb_v,
                                 input bit poke_mid);
        logic [7:0] exp;
        exp = 8'(ta) * 8'(tb_v);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_busy"}, {7'd0, bus.busy}, 8'd1);
            check({tag, "_nodone"}, {7'd0, bus.done}, 8'd0);
            check({tag, "_phold"}, bus.p, last_p);
            if (poke_mid && i == 1) begin
                bus.start = 1'b1;
                bus.a     = 4'd15;
                bus.b     = 4'd15;
            end else begin
                bus.start = 1'b0;
                bus.a     = 4'($urandom_range(0, 15));
                bus.b     = 4'($urandom_range(0, 15));
            end
            tick();
        end
        bus.start = 1'b0;
        check({tag, "_done"}, {7'd0, bus.done}, 8'd1);
        check({tag, "_busy_lo"}, {7'd0, bus.busy}, 8'd0);
        check({tag, "_p"}, bus.p, exp);
        last_p = exp;
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        last_p    = 8'h00;
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.a     = 4'd0;
        bus.b     = 4'd0;
        tick();
        check("rst_busy", {7'd0, bus.busy}, 8'd0);
        check("rst_done", {7'd0, bus.done}, 8'd0);
        check("rst_p", bus.p, 8'h00);

        // start already high as reset releases: accepted at the first edge
        rst = 1'b0;
        tick();
        bus.start = 1'b0;
        run_and_check("zero", 4'd0, 4'd0, 1'b0);

        tick();
        launch(4'd8, 4'd7);
        run_and_check("m8x7", 4'd8, 4'd7, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_p", bus.p, 8'd56);
            check("hold_done", {7'd0, bus.done}, 8'd0);
        end

        launch(4'd15, 4'd15);
        run_and_check("m15x15", 4'd15, 4'd15, 1'b0);

        // Back-to-back: second start issued in the DONE cycle
        tick();
        launch(4'd1, 4'd1);
        run_and_check("b2b_1", 4'd1, 4'd1, 1'b0);
        launch(4'd3, 4'd5);
        run_and_check("b2b_2", 4'd3, 4'd5, 1'b0);

        tick();
        launch(4'd6, 4'd2);
        run_and_check("midstart", 4'd6, 4'd2, 1'b1);

        // Asynchronous reset two cycles into RUN
        tick();
        launch(4'd9, 4'd9);
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", {7'd0, bus.busy}, 8'd0);
        check("abort_p", bus.p, 8'h00);
        check("abort_done", {7'd0, bus.done}, 8'd0);
        tick();
        rst = 1'b0;
        last_p = 8'h00;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("idle_busy", {7'd0, bus.busy}, 8'd0);
            check("idle_done", {7'd0, bus.done}, 8'd0);
        end
        launch(4'd2, 4'd3);
        run_and_check("post_rst", 4'd2, 4'd3, 1'b0);

        // Random operands, alternating idle gaps and back-to-back issue
        for (int n = 0; n < 24; n++) begin
            logic [3:0] ra;
            logic [3:0] rb;
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            if (n % 2 == 0) begin
                tick();
            end
            launch(ra, rb);
            run_and_check("rand", ra, rb, 1'b0);
        end

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mult4_seq
